// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with fixed access latency,
// RV32I sub-word lane steering, sign/zero extension and alignment/range/funct3 checks.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            a_we;
    logic [31:0]     a_addr;
    logic [31:0]     a_wdata;
    logic [2:0]      a_func3;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   word_idx;
    logic [31:0]     rd_word;
    logic [1:0]      lane;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            misalign;
    logic            out_of_range;
    logic            illegal;
    logic            err_c;
    logic [31:0]     rdata_c;
    logic [3:0]      wmask_c;
    logic [31:0]     wword_c;
    logic            mem_we;
    logic            accept;
    logic            execute;

    assign accept   = (state == S_IDLE) && req_valid && req_ready;
    assign execute  = (state == S_WAIT) && (cnt == '0);
    assign word_idx = a_addr[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign lane     = a_addr[1:0];
    assign byte_v   = 8'(rd_word >> {lane, 3'b000});
    assign half_v   = 16'(rd_word >> {a_addr[1], 4'b0000});

    // Decode the captured request into error flag, load result and store lane mask
    always_comb begin
        illegal      = 1'b0;
        rdata_c      = '0;
        wmask_c      = '0;
        wword_c      = '0;
        misalign     = ((a_func3[1:0] == 2'd1) && a_addr[0]) ||
                       ((a_func3[1:0] == 2'd2) && (a_addr[1:0] != 2'd0));
        out_of_range = ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS));
        if (a_we) begin
            case (a_func3)
                3'd0: begin
                    wmask_c = 4'b0001 << lane;
                    wword_c = {4{a_wdata[7:0]}};
                end
                3'd1: begin
                    wmask_c = a_addr[1] ? 4'b1100 : 4'b0011;
                    wword_c = {2{a_wdata[15:0]}};
                end
                3'd2: begin
                    wmask_c = 4'b1111;
                    wword_c = a_wdata;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (a_func3)
                3'd0:    rdata_c = {{24{byte_v[7]}}, byte_v};
                3'd1:    rdata_c = {{16{half_v[15]}}, half_v};
                3'd2:    rdata_c = rd_word;
                3'd4:    rdata_c = {24'd0, byte_v};
                3'd5:    rdata_c = {16'd0, half_v};
                default: illegal = 1'b1;
            endcase
        end
        err_c = misalign || out_of_range || illegal;
        if (err_c) begin
            rdata_c = '0;
        end
    end

    // Write is suppressed when reset lands on the executing edge
    assign mem_we = reset && execute && a_we && !err_c;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_c[b]) begin
                    mem[word_idx][8*b +: 8] <= wword_c[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_we    <= req_we;
            a_addr  <= req_addr;
            a_wdata <= req_wdata;
            a_func3 <= req_func3;
        end
    end

    // Request/response sequencing; response fields are captured once and held in RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        cnt       <= CW'(LATENCY - 1);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_c;
                        rsp_err   <= err_c;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the target end of the core's load/store request interface. It accepts one request at a time over a valid/ready handshake, models a fixed multi-cycle access latency, and applies RV32I sub-word rules (byte/half lane steering, sign/zero extension, alignment and range checks). It returns a single response per request and sits between the datapath's memory port and a word-addressed storage array held inside the block.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words of storage; must be a power of two.
- LATENCY, 2: number of WAIT-state cycles between acceptance and response; legal range 1–15.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bytes are used for sb/sh.
- req_func3  in  3  RV32I funct3. Loads: 0=lb, 1=lh, 2=lw, 4=lbu, 5=lhu. Stores: 0=sb, 1=sh, 2=sw.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  request rejected (misaligned, out of range, or illegal funct3).

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, the block captures we, addr, wdata and func3, loads cnt = LATENCY-1, and goes to WAIT.
- WAIT:
  - If cnt ≠ 0, cnt decrements.
  - If cnt = 0, the access executes on this edge and the FSM goes to RESP.
- RESP:
  - rsp_valid = 1 and the response fields are held stable.
  - On rsp_ready the FSM returns to IDLE.
  - There is no bypass from RESP to IDLE to a new accept in the same cycle; req_ready is 0 in RESP.
- Error checks, evaluated on the captured request:
  - Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0.
  - Out of range: addr[31:2] ≥ DEPTH_WORDS.
  - Illegal funct3: loads with 3, 6 or 7; stores with any value >2.
  - On any error: rsp_err=1, rsp_rdata=0, and storage is not modified.
- Loads read word = mem[addr[31:2]]:
  - lb/lbu use byte lane addr[1:0]; lh/lhu use half lane addr[1].
  - lb and lh sign-extend; lbu and lhu zero-extend.
- Stores write only the addressed lanes:
  - sb writes wdata[7:0] to lane addr[1:0].
  - sh writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - sw writes all four lanes.
  - The store response carries rsp_rdata=0 and rsp_err=0.
- Storage contents are not initialised by reset.

## Timing
- Reset (reset=0 at a clk edge):
  - FSM → IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready is forced to 0 while reset=0 and is 1 from the first cycle after release.
- Acceptance happens in cycle 0. WAIT occupies cycles 1..LATENCY. rsp_valid is first high in cycle LATENCY+1.
- The store commits on the WAIT→RESP edge. A load in a later request observes the new data.
- rsp_valid, rsp_rdata and rsp_err are registered and do not change while rsp_valid=1 and rsp_ready=0.
- When rsp_ready is already 1 as RESP is entered, the response lasts exactly one cycle.
- Maximum throughput is one request per LATENCY+2 cycles.
- Reset in WAIT: the request is dropped and no write occurs. Reset in RESP: the response is dropped and the write has already occurred.
- Inputs other than req_* in IDLE and rsp_ready in RESP are ignored.

## Test plan
- Reset: after reset=0 for 2 cycles, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0. On release, req_ready=1 in the next cycle.
- Word store/load, LATENCY=2:
  - sw addr=0x10, wdata=0xDEADBEEF is accepted in cycle 0, and rsp_valid=1, rsp_err=0 appear in cycle 3.
  - lw addr=0x10 then returns 0xDEADBEEF.
- Sub-word behaviour:
  - sb addr=0x13, wdata=0x80 updates mem word 4 to 0x80ADBEEF.
  - lb addr=0x13 returns 0xFFFFFF80; lbu returns 0x00000080.
  - lh addr=0x12 returns 0xFFFF80AD; lhu returns 0x000080AD.
- Errors, each returning rsp_err=1, rsp_rdata=0 with memory unchanged:
  - lw addr=0x11.
  - sh addr=0x13.
  - lw addr=4·DEPTH_WORDS.
  - load with func3=3.
- Backpressure: rsp_ready is held 0 for 5 cycles in RESP. rsp_valid and the data stay stable and req_ready stays 0. The cycle after rsp_ready=1, req_ready=1.
- Reset mid-WAIT: sw addr=0x20, wdata=0x1234 with reset asserted in cycle 1, then a later lw addr=0x20 returns the prior contents (pre-loaded 0xAAAA5555).
